// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle MIPS DIV/DIVU unit.
// Holds the FSM encoding, datapath widths and the operand magnitude helper.
package div_unit_pkg;

    localparam int ITER         = 32;
    localparam int CNT_W        = 6;
    localparam int DATA_W       = 32;
    localparam int DOUBLE_W     = 64;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Magnitude of x when treated as signed; raw value for unsigned divides.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                  input logic              is_signed);
        return (is_signed && x[DATA_W-1]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring 32/32 divider answering the EX stage's start/ready handshake.
// result_o = {remainder, quotient}; both outputs are registered.
//
// state      | meaning
// DIV_FREE   | idle, waiting for start_i
// DIV_BYZERO | divisor was zero, zero result next edge
// DIV_ON     | one restoring step per edge, 32 steps then result load
// DIV_END    | result held until EX drops start_i
module div_unit
    import div_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [DOUBLE_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DOUBLE_W:0]     work_q, work_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DOUBLE_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic [DATA_W:0]       diff;
    logic [DATA_W-1:0]     quot_fix;
    logic [DATA_W-1:0]     rem_fix;

    assign diff     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign quot_fix = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    assign rem_fix  = neg_rem_q  ? (~work_q[64:33] + 32'd1) : work_q[64:33];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_NOT_READY;
                result_d = '0;
                if (start_i && !annul_i) begin
                    divisor_d  = abs_val(opdata2_i, signed_div_i);
                    work_d     = {32'b0, abs_val(opdata1_i, signed_div_i), 1'b0};
                    neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d  = signed_div_i & opdata1_i[31];
                    cnt_d      = '0;
                    state_d    = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    cnt_d    = '0;
                    ready_d  = DIV_NOT_READY;
                    result_d = '0;
                end else if (cnt_q == CNT_W'(ITER)) begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DIV_READY;
                    state_d  = DIV_END;
                end else begin
                    // Borrow out means the divisor did not fit: shift in a 0 quotient bit.
                    work_d = diff[32] ? {work_q[63:0], 1'b0}
                                      : {diff[31:0], work_q[31:0], 1'b1};
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            DIV_END: begin
                if (!start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_NOT_READY;
                    result_d = '0;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, randomized
// operands against an arithmetic reference, and handshake corner sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    // Reference: {remainder, quotient} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts at a negedge; returns latency (edges after accept) and result.
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output int lat, output logic [63:0] res);
        int edges;
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        edges        = 0;
        lat          = -1;
        res          = 'x;
        while (edges < 60) begin
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sg;
            end
            if (ready_o === 1'b1) begin
                lat = edges - 1;
                res = result_o;
                break;
            end
        end
        for (int i = 0; i < hold; i++) begin
            annul_i = (i == 1);
            @(negedge clk);
            check64("hold_result", result_o, res);
            check_int("hold_ready", int'(ready_o), 1);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);
        check_int("drop_ready", int'(ready_o), 0);
        check64("drop_result", result_o, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic [31:0] a, b;
        logic        sg;
        int          seen;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},          33};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},          33};
        vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},          33};
        vecs[5] = '{1'b0, 32'd1234,       32'd0,          64'd0,                          1};
        vecs[6] = '{1'b1, 32'h80000000,   32'd0,          64'd0,                          1};
        vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC},          33};
        vecs[8] = '{1'b0, 32'd5,          32'd7,          {32'd5, 32'd0},                 33};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        check_int("reset_ready", int'(ready_o), 0);
        check64("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_div(vecs[i].sg, vecs[i].a, vecs[i].b, 0, lat, res);
            check64($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Result held while start_i stays high; annul_i ignored in DIV_END.
        do_div(1'b0, 32'd1000, 32'd33, 5, lat, res);
        check64("hold_seq_result", res, {32'd10, 32'd30});

        // Annul at iteration 10: nothing delivered, next request works.
        signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd4; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen++;
        end
        check_int("annul_no_ready", seen, 0);
        do_div(1'b0, 32'd50, 32'd5, 0, lat, res);
        check64("after_annul_result", res, {32'd0, 32'd10});
        check_int("after_annul_latency", lat, 33);

        // Annul while in DIV_BYZERO returns to idle without a result.
        signed_div_i = 1'b0; opdata1_i = 32'd8; opdata2_i = 32'd0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check_int("byzero_annul_ready", int'(ready_o), 0);
        @(negedge clk);
        check_int("byzero_annul_ready2", int'(ready_o), 0);

        // Synchronous reset at iteration 20.
        signed_div_i = 1'b1; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        check_int("midrst_ready", int'(ready_o), 0);
        check64("midrst_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_div(1'b1, 32'hFFFFFF9C, 32'd7, 0, lat, res);
        check64("after_rst_result", res, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
        check_int("after_rst_latency", lat, 33);

        // Randomized operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'h80000000;
                1:       a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
            do_div(sg, a, b, 0, lat, res);
            check64($sformatf("rand%0d_result(sg=%0d a=%h b=%h)", n, sg, a, b), res,
                    ref_div(sg, a, b));
            check_int($sformatf("rand%0d_latency", n), lat, (b == 32'd0) ? 1 : 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
